bip_control: RTL and testbench

//  BIP I control unit, directly downstream of PC: consumes the instruction word

---
 rtl/bip_control_pkg.sv | 35 +++
 rtl/bip_control_if.sv | 30 +++
 rtl/bip_control_decoder.sv | 44 ++++
 rtl/bip_control.sv | 72 +++++++
 tb/tb_bip_control.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bip_control_pkg.sv
// Shared definitions for the BIP I control unit: field widths, opcodes,
// datapath select encodings, control vector and FSM state type.
package bip_control_pkg;

  localparam int unsigned OPC_W   = 5;
  localparam int unsigned OPND_W  = 11;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned INSTR_W = OPC_W + OPND_W;

  localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

  typedef enum logic [1:0] {SELA_RAM = 2'd0, SELA_IMM = 2'd1, SELA_ALU = 2'd2} sela_e;
  typedef enum logic {SELB_RAM = 1'b0, SELB_IMM = 1'b1} selb_e;
  typedef enum logic {ALU_ADD = 1'b0, ALU_SUB = 1'b1} alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  typedef struct packed {
    logic    wr_pc;
    sela_e   sel_a;
    selb_e   sel_b;
    logic    wr_acc;
    alu_op_e op;
    logic    wr_ram;
    logic    rd_ram;
  } ctrl_t;

endpackage

// File: rtl/bip_control_if.sv
// Instruction-in / datapath-control-out bundle between the BIP control unit
// (master) and the PC, program memory, ACC/ALU and data RAM (slave side).
interface bip_control_if;
  import bip_control_pkg::*;

  logic [INSTR_W-1:0] Instr;
  logic               WrPC;
  logic [1:0]         SelA;
  logic               SelB;
  logic               WrAcc;
  logic               Op;
  logic               WrRam;
  logic               RdRam;
  logic [OPND_W-1:0]  Operand;
  logic               Halted;
  logic               IllegalOp;
  logic [CNT_W-1:0]   CycleCount;

  modport master (
    input  Instr,
    output WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand,
           Halted, IllegalOp, CycleCount
  );

  modport slave (
    output Instr,
    input  WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand,
           Halted, IllegalOp, CycleCount
  );
endinterface

// File: rtl/bip_control_decoder.sv
// Pure combinational BIP I opcode decoder: opcode -> control vector,
// plus halt and undefined-opcode flags.
module bip_decoder
  import bip_control_pkg::*;
(
  input  logic [OPC_W-1:0] opc_i,
  output ctrl_t            ctrl_o,
  output logic             halt_o,
  output logic             illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    case (opc_i)
      OPC_HLT:  halt_o = 1'b1;
      OPC_STO:  begin ctrl_o.wr_ram = 1'b1; ctrl_o.wr_pc = 1'b1; end
      OPC_LD:   begin
        ctrl_o.rd_ram = 1'b1; ctrl_o.sel_a = SELA_RAM;
        ctrl_o.wr_acc = 1'b1; ctrl_o.wr_pc = 1'b1;
      end
      OPC_LDI:  begin
        ctrl_o.sel_a = SELA_IMM; ctrl_o.wr_acc = 1'b1; ctrl_o.wr_pc = 1'b1;
      end
      OPC_ADD, OPC_SUB: begin
        ctrl_o.rd_ram = 1'b1; ctrl_o.sel_b = SELB_RAM;
        ctrl_o.op     = (opc_i == OPC_SUB) ? ALU_SUB : ALU_ADD;
        ctrl_o.sel_a  = SELA_ALU; ctrl_o.wr_acc = 1'b1; ctrl_o.wr_pc = 1'b1;
      end
      OPC_ADDI, OPC_SUBI: begin
        ctrl_o.sel_b = SELB_IMM;
        ctrl_o.op    = (opc_i == OPC_SUBI) ? ALU_SUB : ALU_ADD;
        ctrl_o.sel_a = SELA_ALU; ctrl_o.wr_acc = 1'b1; ctrl_o.wr_pc = 1'b1;
      end
      // Undefined opcodes execute as NOP so the PC still advances.
      default: begin
        ctrl_o.wr_pc = 1'b1;
        illegal_o    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// BIP I control unit: run/halt FSM, gating of decoded strobes to S_RUN,
// registered illegal-opcode flag and saturating executed-cycle counter.
module bip_control
  import bip_control_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  bip_control_if.master bus
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t             dec_ctrl, ctrl;
  logic              dec_halt, dec_illegal;
  logic [OPND_W-1:0] operand;

  bip_decoder u_decoder (
    .opc_i     (bus.Instr[INSTR_W-1:OPND_W]),
    .ctrl_o    (dec_ctrl),
    .halt_o    (dec_halt),
    .illegal_o (dec_illegal)
  );

  // Outside S_RUN the decoder result is discarded entirely, so an X
  // instruction word in idle/halt never reaches the outputs.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
    ctrl      = '0;
    operand   = '0;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        ctrl      = dec_ctrl;
        operand   = bus.Instr[OPND_W-1:0];
        illegal_d = dec_illegal;
        if (dec_halt) state_d = S_HALT;
        if (cnt_q != '1) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.WrPC       = ctrl.wr_pc;
  assign bus.SelA       = ctrl.sel_a;
  assign bus.SelB       = ctrl.sel_b;
  assign bus.WrAcc      = ctrl.wr_acc;
  assign bus.Op         = ctrl.op;
  assign bus.WrRam      = ctrl.wr_ram;
  assign bus.RdRam      = ctrl.rd_ram;
  assign bus.Operand    = operand;
  assign bus.Halted     = (state_q == S_HALT);
  assign bus.IllegalOp  = illegal_q;
  assign bus.CycleCount = cnt_q;

endmodule

// File: tb/tb_bip_control.sv
// Directed self-checking bench for bip_control: reset bubble, program
// sequence, illegal opcodes, halt behaviour and counter saturation.
module tb_bip_control;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  bip_control_if bus ();

  bip_control dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // {WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand}
  logic [18:0] outs;
  assign outs = {bus.WrPC, bus.SelA, bus.SelB, bus.WrAcc, bus.Op,
                 bus.WrRam, bus.RdRam, bus.Operand};

  function automatic logic [18:0] ev(input logic wrpc, input logic [1:0] sela,
                                     input logic selb, input logic wracc,
                                     input logic op, input logic wrram,
                                     input logic rdram, input logic [10:0] opnd);
    return {wrpc, sela, selb, wracc, op, wrram, rdram, opnd};
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the DUT in S_RUN with CycleCount=0, one cycle after the IDLE bubble.
  task automatic do_reset();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.Instr = 16'h1805;
    cyc();
    @(negedge Clk);
    checks++;
    if ({outs, bus.Halted, bus.IllegalOp, bus.CycleCount} !== '0) begin
      errors++;
      $display("FAIL reset_vals: got outs=%h H=%b I=%b C=%h, want all 0",
               outs, bus.Halted, bus.IllegalOp, bus.CycleCount);
    end
    cyc();
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL idle_bubble: got outs=%h, want 0", outs);
    end
    cyc();
    @(negedge Clk);
    checks++;
    if (outs !== ev(1, 1, 0, 1, 0, 0, 0, 11'd5)) begin
      errors++;
      $display("FAIL first_ldi: got outs=%h, want %h", outs, ev(1, 1, 0, 1, 0, 0, 0, 11'd5));
    end
    checks++;
    if (bus.CycleCount !== 16'd0) begin
      errors++;
      $display("FAIL first_cnt: got %h, want 0000", bus.CycleCount);
    end
  endtask

  task automatic test_program();
    logic [15:0] prog [5];
    logic [18:0] expv [5];
    prog = '{16'h1803, 16'h2804, 16'h300A, 16'h0814, 16'h0000};
    expv[0] = ev(1, 1, 0, 1, 0, 0, 0, 11'd3);
    expv[1] = ev(1, 2, 1, 1, 0, 0, 0, 11'd4);
    expv[2] = ev(1, 2, 0, 1, 1, 0, 1, 11'd10);
    expv[3] = ev(1, 0, 0, 0, 0, 1, 0, 11'd20);
    expv[4] = ev(0, 0, 0, 0, 0, 0, 0, 11'd0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.Instr = prog[i];
      @(negedge Clk);
      checks++;
      if (outs !== expv[i] || bus.CycleCount !== 16'(i) || bus.Halted !== 1'b0) begin
        errors++;
        $display("FAIL prog_step%0d: got outs=%h C=%h H=%b, want outs=%h C=%h H=0",
                 i, outs, bus.CycleCount, bus.Halted, expv[i], 16'(i));
      end
      cyc();
    end
    bus.Instr = 16'h1805;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if (outs !== '0 || bus.Halted !== 1'b1 || bus.CycleCount !== 16'd5) begin
        errors++;
        $display("FAIL halt_ldi%0d: got outs=%h H=%b C=%h, want 0/1/0005",
                 i, outs, bus.Halted, bus.CycleCount);
      end
      cyc();
    end
    bus.Instr = 'x;
    @(negedge Clk);
    checks++;
    if (outs !== '0 || bus.IllegalOp !== 1'b0 || bus.CycleCount !== 16'd5) begin
      errors++;
      $display("FAIL halt_x: got outs=%h I=%b C=%h, want 0/0/0005",
               outs, bus.IllegalOp, bus.CycleCount);
    end
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (outs !== '0 || bus.Halted !== 1'b0 || bus.CycleCount !== 16'd0) begin
      errors++;
      $display("FAIL halt_reset: got outs=%h H=%b C=%h, want 0/0/0000",
               outs, bus.Halted, bus.CycleCount);
    end
    cyc();
    bus.Instr = 16'h1805;
    @(negedge Clk);
    checks++;
    if (outs !== ev(1, 1, 0, 1, 0, 0, 0, 11'd5)) begin
      errors++;
      $display("FAIL halt_rerun: got outs=%h, want %h", outs, ev(1, 1, 0, 1, 0, 0, 0, 11'd5));
    end
  endtask

  task automatic test_illegal();
    do_reset();
    bus.Instr = 16'hF800;
    @(negedge Clk);
    checks++;
    if (outs !== ev(1, 0, 0, 0, 0, 0, 0, 11'd0) || bus.IllegalOp !== 1'b0) begin
      errors++;
      $display("FAIL illegal_decode: got outs=%h I=%b, want %h I=0",
               outs, bus.IllegalOp, ev(1, 0, 0, 0, 0, 0, 0, 11'd0));
    end
    cyc();
    bus.Instr = 16'h1801;
    @(negedge Clk);
    checks++;
    if (bus.IllegalOp !== 1'b1 || outs !== ev(1, 1, 0, 1, 0, 0, 0, 11'd1)) begin
      errors++;
      $display("FAIL illegal_flag: got I=%b outs=%h, want I=1 outs=%h",
               bus.IllegalOp, outs, ev(1, 1, 0, 1, 0, 0, 0, 11'd1));
    end
    cyc();
    @(negedge Clk);
    checks++;
    if (bus.IllegalOp !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: got I=%b, want 0", bus.IllegalOp);
    end
    cyc();
    for (int unsigned o = 8; o < 32; o++) begin
      bus.Instr = {5'(o), 11'h7FF};
      @(negedge Clk);
      checks++;
      if (outs !== ev(1, 0, 0, 0, 0, 0, 0, 11'h7FF)) begin
        errors++;
        $display("FAIL nop_opc%0d: got outs=%h, want %h", o, outs, ev(1, 0, 0, 0, 0, 0, 0, 11'h7FF));
      end
      cyc();
    end
    checks++;
    if (bus.IllegalOp !== 1'b1) begin
      errors++;
      $display("FAIL illegal_held: got I=%b, want 1", bus.IllegalOp);
    end
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (bus.IllegalOp !== 1'b0 || outs !== '0) begin
      errors++;
      $display("FAIL illegal_reset: got I=%b outs=%h, want 0/0", bus.IllegalOp, outs);
    end
  endtask

  task automatic test_hlt_reset();
    do_reset();
    bus.Instr = 16'h0000;
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL hlt_decode: got outs=%h, want 0", outs);
    end
    cyc();
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (bus.Halted !== 1'b0 || outs !== '0 || bus.CycleCount !== 16'd0) begin
      errors++;
      $display("FAIL hlt_reset_idle: got H=%b outs=%h C=%h, want 0/0/0000",
               bus.Halted, outs, bus.CycleCount);
    end
    cyc();
    bus.Instr = 16'h1805;
    @(negedge Clk);
    checks++;
    if (outs !== ev(1, 1, 0, 1, 0, 0, 0, 11'd5)) begin
      errors++;
      $display("FAIL hlt_reset_run: got outs=%h, want %h", outs, ev(1, 1, 0, 1, 0, 0, 0, 11'd5));
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.Instr = 16'h2801;
    repeat (65534) cyc();
    @(negedge Clk);
    checks++;
    if (bus.CycleCount !== 16'hFFFE) begin
      errors++;
      $display("FAIL cnt_fffe: got %h, want FFFE", bus.CycleCount);
    end
    cyc();
    @(negedge Clk);
    checks++;
    if (bus.CycleCount !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_ffff: got %h, want FFFF", bus.CycleCount);
    end
    repeat (5) cyc();
    @(negedge Clk);
    checks++;
    if (bus.CycleCount !== 16'hFFFF || outs !== ev(1, 2, 1, 1, 0, 0, 0, 11'd1)) begin
      errors++;
      $display("FAIL cnt_sat: got C=%h outs=%h, want FFFF %h",
               bus.CycleCount, outs, ev(1, 2, 1, 1, 0, 0, 0, 11'd1));
    end
  endtask

  initial begin
    bus.Instr = '0;
    test_reset();
    test_program();
    test_illegal();
    test_hlt_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
